// File: rtl/tpo_frame_receiver.sv
// tpo_frame_receiver: assembles serial two-out-of-five frames {a,b,c,d,e},
// decodes them to BCD (weights 7-4-2-1-0) and presents the result through a
// one-entry valid/ready output register. Counts invalid and aborted frames.
module tpo_frame_receiver #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic             out_err,
  output logic [4:0]       out_code,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [4:0] sreg;

  logic       accept;
  logic       slot_free;
  logic       load;
  logic       err_inc;
  logic [4:0] load_frame;
  logic [3:0] load_digit;

  // 2-of-5 decode; any code without exactly two ones maps to 4'hF
  function automatic logic [3:0] decode(input logic [4:0] code);
    logic [3:0] d;
    case (code)
      5'b11000: d = 4'd0;
      5'b00011: d = 4'd1;
      5'b00101: d = 4'd2;
      5'b00110: d = 4'd3;
      5'b01001: d = 4'd4;
      5'b01010: d = 4'd5;
      5'b01100: d = 4'd6;
      5'b10001: d = 4'd7;
      5'b10010: d = 4'd8;
      5'b10100: d = 4'd9;
      default:  d = 4'hF;
    endcase
    return d;
  endfunction

  // Saturating increment of the error counter
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_ready  = (state != HOLD);
  assign accept    = in_valid & in_ready;
  assign slot_free = ~out_valid | out_ready;

  // Decide whether the output register loads this cycle and whether an error is counted
  always_comb begin
    load       = 1'b0;
    load_frame = sreg;
    err_inc    = 1'b0;
    case (state)
      SHIFT: begin
        if (accept) begin
          if (in_sof) begin
            err_inc = 1'b1;
          end else if (cnt == 3'd4) begin
            load_frame = {sreg[3:0], in_bit};
            load       = slot_free;
          end
        end
      end
      HOLD:    load = slot_free;
      default: ;
    endcase
    load_digit = decode(load_frame);
    if (load && (load_digit == 4'hF)) err_inc = 1'b1;
  end

  // Framing FSM: collect bits, restart on a mid-frame sof, park a complete frame in HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      sreg  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && in_sof) begin
            sreg  <= {4'd0, in_bit};
            cnt   <= 3'd1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            if (in_sof) begin
              sreg <= {4'd0, in_bit};
              cnt  <= 3'd1;
            end else if (cnt == 3'd4) begin
              sreg  <= load_frame;
              cnt   <= 3'd0;
              state <= load ? IDLE : HOLD;
            end else begin
              sreg <= {sreg[3:0], in_bit};
              cnt  <= cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (slot_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: a new load wins over a same-cycle consumer pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_digit <= 4'd0;
      out_err   <= 1'b0;
      out_code  <= 5'd0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_digit <= load_digit;
      out_err   <= (load_digit == 4'hF);
      out_code  <= load_frame;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error counter: clear has priority over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (err_inc) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_tpo_frame_receiver.sv
// Directed bench for tpo_frame_receiver: inputs change 1ns after each rising
// edge and outputs are sampled at that same point.
module tb_tpo_frame_receiver;

  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_bit = 1'b0;
  logic             in_sof = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [3:0]       out_digit;
  logic             out_err;
  logic [4:0]       out_code;
  logic [ERR_W-1:0] err_cnt;
  logic             clr_cnt = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  tpo_frame_receiver #(.ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_err(out_err), .out_code(out_code), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b, input logic sof);
    in_valid = 1'b1; in_bit = b; in_sof = sof;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [4:0] code);
    for (int i = 4; i >= 0; i--) send_bit(code[i], i == 4);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vectors++; if (out_digit !== 4'd0) begin miscompares++; $display("FAIL rst_out_digit got %h want 0", out_digit); end
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL rst_out_err got %b want 0", out_err); end
    vectors++; if (out_code !== 5'd0) begin miscompares++; $display("FAIL rst_out_code got %b want 00000", out_code); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    send_bit(1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
    vectors++; if (out_digit !== 4'd9) begin miscompares++; $display("FAIL single_digit got %h want 9", out_digit); end
    vectors++; if (out_code !== 5'b10100) begin miscompares++; $display("FAIL single_code got %b want 10100", out_code); end
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL single_err got %b want 0", out_err); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL single_err_cnt got %0d want 0", err_cnt); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    int pulses;
    apply_reset();
    out_ready = 1'b1;
    bits = 10'b11000_00011;
    pulses = 0;
    for (int i = 9; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = bits[i]; in_sof = (i == 9) || (i == 4);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready bit %0d got %b want 1", 9 - i, in_ready); end
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
      if (i == 5) begin
        vectors++; if (out_valid !== 1'b1 || out_digit !== 4'd0) begin miscompares++; $display("FAIL b2b_first got v=%b d=%h want v=1 d=0", out_valid, out_digit); end
      end
      if (i == 0) begin
        vectors++; if (out_valid !== 1'b1 || out_digit !== 4'd1) begin miscompares++; $display("FAIL b2b_second got v=%b d=%h want v=1 d=1", out_valid, out_digit); end
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk); #1;
    if (out_valid === 1'b1) pulses++;
    vectors++; if (pulses != 2) begin miscompares++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_errors();
    apply_reset();
    out_ready = 1'b1;
    send_frame(5'b11100);
    vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL err1_flag got %b want 1", out_err); end
    vectors++; if (out_digit !== 4'hF) begin miscompares++; $display("FAIL err1_digit got %h want F", out_digit); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL err1_valid got %b want 1", out_valid); end
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL err1_cnt got %0d want 1", err_cnt); end
    send_frame(5'b00000);
    vectors++; if (err_cnt !== 8'd2) begin miscompares++; $display("FAIL err2_cnt got %0d want 2", err_cnt); end
    vectors++; if (out_code !== 5'b00000 || out_err !== 1'b1) begin miscompares++; $display("FAIL err2_out got code=%b err=%b want 00000/1", out_code, out_err); end
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    clr_cnt = 1'b1;
    send_bit(1'b0, 1'b0);
    clr_cnt = 1'b0;
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL err3_clr_wins got %0d want 0", err_cnt); end
    vectors++; if (out_code !== 5'b11110 || out_err !== 1'b1) begin miscompares++; $display("FAIL err3_out got code=%b err=%b want 11110/1", out_code, out_err); end
  endtask

  task automatic test_abort();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_bit(i[0], 1'b0);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_ignore bit %0d got v=%b want 0", i, out_valid); end
    end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL idle_err_cnt got %0d want 0", err_cnt); end
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL abort_cnt got %0d want 1", err_cnt); end
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_early got v=%b want 0", out_valid); end
    send_bit(1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b1 || out_digit !== 4'd5) begin miscompares++; $display("FAIL abort_digit got v=%b d=%h want 1/5", out_valid, out_digit); end
    vectors++; if (out_code !== 5'b01010 || out_err !== 1'b0) begin miscompares++; $display("FAIL abort_code got %b err=%b want 01010/0", out_code, out_err); end
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL abort_cnt_final got %0d want 1", err_cnt); end
  endtask

  task automatic test_hold();
    apply_reset();
    out_ready = 1'b0;
    send_frame(5'b00110);
    vectors++; if (out_valid !== 1'b1 || out_digit !== 4'd3) begin miscompares++; $display("FAIL hold_first got v=%b d=%h want 1/3", out_valid, out_digit); end
    send_frame(5'b01001);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b1 || out_digit !== 4'd3 || out_code !== 5'b00110) begin miscompares++; $display("FAIL hold_stable got v=%b d=%h c=%b want 1/3/00110", out_valid, out_digit, out_code); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready2 got %b want 0", in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1 || out_digit !== 4'd4 || out_code !== 5'b01001) begin miscompares++; $display("FAIL hold_release got v=%b d=%h c=%b want 1/4/01001", out_valid, out_digit, out_code); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_in_ready3 got %b want 1", in_ready); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_pop got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    send_frame(5'b11100);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_digit !== 4'd0 || out_err !== 1'b0 || out_code !== 5'd0) begin miscompares++; $display("FAIL rstmid_out got v=%b d=%h e=%b c=%b want 0/0/0/00000", out_valid, out_digit, out_err, out_code); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rstmid_cnt got %0d want 0", err_cnt); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send_frame(5'b00011);
    send_frame(5'b10001);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rsthold_pre got %b want 0", in_ready); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_code !== 5'd0) begin miscompares++; $display("FAIL rsthold_out got rdy=%b v=%b c=%b want 1/0/00000", in_ready, out_valid, out_code); end
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rsthold_lost got %b want 0", out_valid); end
    send_frame(5'b10010);
    vectors++; if (out_valid !== 1'b1 || out_digit !== 4'd8 || out_err !== 1'b0) begin miscompares++; $display("FAIL rst_next got v=%b d=%h e=%b want 1/8/0", out_valid, out_digit, out_err); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_next_cnt got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_abort();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpo_frame_receiver.md
Name: tpo_frame_receiver

Overview:
- Receives a serial two-out-of-five coded stream, one bit per handshake, and assembles 5-bit frames (bits a,b,c,d,e in that order).
- Checks each frame for exactly two ones and decodes it to a BCD digit with weights a=7, b=4, c=2, d=1, e=0 (11000 = digit 0).
- Presents the result through a one-entry valid/ready output register.
- Sits directly downstream of the serial line interface and upstream of the digit consumer. It is the clocked framing stage around the team's combinational 2-of-5 validity check.

Parameters:
- ERR_W, 8, width of the saturating frame-error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  serial bit present.
- in_ready  out  1  receiver accepts the bit this cycle.
- in_bit  in  1  serial data bit.
- in_sof  in  1  qualifies in_bit as bit a, the first bit of a frame.
- out_valid  out  1  decoded frame held in the output register.
- out_ready  in  1  consumer takes the output this cycle.
- out_digit  out  4  decoded BCD digit 0..9; 4'hF when the frame is invalid.
- out_err  out  1  frame is not a valid 2-of-5 code.
- out_code  out  5  raw frame {a,b,c,d,e}.
- err_cnt  out  ERR_W  saturating count of invalid and aborted frames.
- clr_cnt  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async): state=IDLE, bit count=0, shift register=0, out_valid=0, out_digit=0, out_err=0, out_code=0, err_cnt=0. in_ready=1 after reset.
- Accept: a bit is accepted when in_valid & in_ready. in_ready = (state != HOLD).
- State IDLE:
  - Accepted bit with in_sof=1: store as bit a, count=1, go to SHIFT.
  - Accepted bit with in_sof=0: discarded silently, stay in IDLE.
- State SHIFT:
  - Accepted bit with in_sof=0: shift it in, count+1.
  - Accepted bit with in_sof=1: abort the partial frame, err_cnt+1 (saturating), restart with this bit as a, count=1.
  - On acceptance of the 5th bit, the complete frame is formed from the 4 held bits plus the incoming bit.
    - If the slot is free (out_valid==0 or out_ready==1 this cycle): load the output register at this edge, go to IDLE. out_valid is high the next cycle, i.e. 1 cycle after the 5th bit.
    - Otherwise: hold the frame and go to HOLD.
- State HOLD:
  - in_ready=0.
  - When out_valid==0 or out_ready==1: load the output register, go to IDLE.
- Output load:
  - out_code = frame.
  - Popcount==2: out_err=0, out_digit per the weight table (00011=1, 00101=2, 00110=3, 01001=4, 01010=5, 01100=6, 10001=7, 10010=8, 10100=9, 11000=0).
  - Any other popcount: out_err=1, out_digit=4'hF, err_cnt+1 (saturating).
  - Invalid frames are still delivered; they are not dropped.
- Output handshake:
  - out_valid clears on out_valid & out_ready unless a new load occurs in the same cycle; a load wins and out_valid stays 1.
  - Output fields are stable while out_valid=1 and out_ready=0.
- err_cnt:
  - Saturates at all-ones.
  - If clr_cnt and an increment occur in the same cycle, the result is 0; clr wins.
- Reset mid-frame or in HOLD: the partial or held frame is lost and no error is counted.
- Throughput: one frame per 5 accepted bits with no bubbles while the consumer keeps out_ready=1.

Test Plan:
- Reset then the frame 1,0,1,0,0 (sof on first bit), out_ready=1 -> out_valid one cycle after the 5th bit, out_digit=9, out_code=10100, out_err=0, err_cnt=0.
- Back-to-back frames 11000 then 00011 with continuous in_valid and out_ready=1 -> digits 0 then 1, in_ready never low, exactly two out_valid pulses.
- Invalid frame 11100 -> out_err=1, out_digit=F, err_cnt=1. Then 00000 -> err_cnt=2. Then clr_cnt coincident with a third invalid frame -> err_cnt=0.
- Sof asserted on the 3rd bit of a frame, followed by 4 more bits forming 01010 -> err_cnt=1, output digit 5. Bits sent while in IDLE without sof -> ignored, no output.
- out_ready=0 holding digit 3 while a second frame 01001 completes -> in_ready=0 in HOLD, digit 3 stable. Raise out_ready -> digit 4 loads on the same edge, out_valid stays 1, then in_ready=1.
- Assert rst after 3 bits of a frame and also while in HOLD -> all outputs return to reset values immediately (async), err_cnt=0. The next full frame decodes correctly.
